// File: rtl/layer_leaky_relu_seq.sv
// Leaky-ReLU activation stage: captures one CHANNELS-wide vector, computes LANES elements per clock.
// Optional feature macro: LRELU_ALPHA_PORT_EN adds a runtime slope port alpha_in.
module layer_leaky_relu_seq #(
   parameter int                     CHANNELS  = 20,
   parameter int                     SIZE      = 16,
   parameter int                     FRAC_BITS = 8,
   parameter int                     LANES     = 4,
   parameter logic signed [SIZE-1:0] ALPHA     = 16'sd26
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*SIZE-1:0]     in_data,
`ifdef LRELU_ALPHA_PORT_EN
   input  logic [SIZE-1:0]              alpha_in,
`endif
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHANNELS*2*SIZE-1:0]   out_data,
   output logic                         busy,
   output logic                         done
);

   localparam int W2     = 2 * SIZE;
   localparam int NCHUNK = (CHANNELS + LANES - 1) / LANES;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int IW     = $clog2(NCHUNK * LANES) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPUTE,
      ST_HOLD
   } state_t;

   state_t                      r_state;
   state_t                      w_nextState;
   logic [CW-1:0]               r_chunk;
   logic [CHANNELS*SIZE-1:0]    r_vec;
   logic [CHANNELS*W2-1:0]      r_outData;
   logic                        r_outValid;
   logic                        r_done;
   logic                        w_accept;
   logic                        w_lastChunk;
   logic                        w_release;
   logic signed [SIZE-1:0]      w_slope;

   logic [IW-1:0]               w_idx    [LANES];
   logic                        w_laneEn [LANES];
   logic signed [SIZE-1:0]      w_x      [LANES];
   logic signed [W2-1:0]        w_res    [LANES];

`ifdef LRELU_ALPHA_PORT_EN
   logic signed [SIZE-1:0]      r_slope;
   assign w_slope = r_slope;
`else
   assign w_slope = ALPHA;
`endif

   assign in_ready  = (r_state == ST_IDLE) && !reset;
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      w_lastChunk = (r_chunk == CW'(NCHUNK - 1));
      case (r_state)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               w_accept    = 1'b1;
               w_nextState = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            if (w_lastChunk) begin
               w_nextState = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               w_release   = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Lanes past the last channel are disabled so they never read or write outside the vectors.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_idx[l]    = IW'(r_chunk) * IW'(LANES) + IW'(l);
         w_laneEn[l] = (w_idx[l] < IW'(CHANNELS));
         w_x[l]      = '0;
         if (w_laneEn[l]) begin
            w_x[l] = r_vec[w_idx[l]*SIZE +: SIZE];
         end
         if (w_x[l][SIZE-1]) begin
            w_res[l] = W2'(w_x[l]) * W2'(w_slope);
         end else begin
            w_res[l] = W2'(w_x[l]) <<< FRAC_BITS;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chunk    <= '0;
         r_vec      <= '0;
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_done     <= 1'b0;
`ifdef LRELU_ALPHA_PORT_EN
         r_slope    <= '0;
`endif
      end else begin
         r_done <= w_release;
         if (w_accept) begin
            r_vec   <= in_data;
            r_chunk <= '0;
`ifdef LRELU_ALPHA_PORT_EN
            r_slope <= alpha_in;
`endif
         end
         if (r_state == ST_COMPUTE) begin
            for (int l = 0; l < LANES; l++) begin
               if (w_laneEn[l]) begin
                  r_outData[w_idx[l]*W2 +: W2] <= w_res[l];
               end
            end
            if (w_lastChunk) begin
               r_chunk    <= '0;
               r_outValid <= 1'b1;
            end else begin
               r_chunk <= r_chunk + 1'b1;
            end
         end
         if (w_release) begin
            r_outValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_layer_leaky_relu_seq.sv
// Self-checking bench for layer_leaky_relu_seq: scoreboard of expected vectors, LANES=4 and LANES=3 instances.
module tb_layer_leaky_relu_seq;

   localparam int CH = 20;
   localparam int SZ = 16;
   localparam int FB = 8;
   localparam int W2 = 32;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 inValid, inReady, outValid, outReady, busy, done;
   logic [CH*SZ-1:0]     inData;
   logic [CH*W2-1:0]     outData;
   logic                 inValid3, inReady3, outValid3, outReady3, busy3, done3;
   logic [CH*SZ-1:0]     inData3;
   logic [CH*W2-1:0]     outData3;
`ifdef LRELU_ALPHA_PORT_EN
   logic [SZ-1:0]        alphaIn, alphaIn3;
`endif

   int total = 0;
   int bad   = 0;
   logic [CH*W2-1:0] sbQueue[$];

   always #5 clk = ~clk;

   layer_leaky_relu_seq #(.CHANNELS(CH), .SIZE(SZ), .FRAC_BITS(FB), .LANES(4)) dut (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
`ifdef LRELU_ALPHA_PORT_EN
      .alpha_in(alphaIn),
`endif
      .out_valid(outValid), .out_ready(outReady), .out_data(outData), .busy(busy), .done(done)
   );

   layer_leaky_relu_seq #(.CHANNELS(CH), .SIZE(SZ), .FRAC_BITS(FB), .LANES(3)) dut3 (
      .clk(clk), .reset(reset), .in_valid(inValid3), .in_ready(inReady3), .in_data(inData3),
`ifdef LRELU_ALPHA_PORT_EN
      .alpha_in(alphaIn3),
`endif
      .out_valid(outValid3), .out_ready(outReady3), .out_data(outData3), .busy(busy3), .done(done3)
   );

   // Arithmetic reference: plain integer scaling, truncated to the 32-bit result.
   function automatic logic [W2-1:0] refLeaky(input logic [SZ-1:0] x, input logic [SZ-1:0] slope);
      longint xv;
      longint sv;
      longint r;
      xv = longint'($signed(x));
      sv = longint'($signed(slope));
      if (xv >= 0) r = xv * (longint'(1) << FB);
      else         r = xv * sv;
      return r[W2-1:0];
   endfunction

   function automatic logic [CH*W2-1:0] refVector(input logic [CH*SZ-1:0] v, input logic [SZ-1:0] slope);
      logic [CH*W2-1:0] r;
      r = '0;
      for (int i = 0; i < CH; i++) r[i*W2 +: W2] = refLeaky(v[i*SZ +: SZ], slope);
      return r;
   endfunction

   function automatic logic [CH*SZ-1:0] fillVector(input logic [SZ-1:0] x);
      logic [CH*SZ-1:0] v;
      for (int i = 0; i < CH; i++) v[i*SZ +: SZ] = x;
      return v;
   endfunction

   // Drives one transaction on the LANES=4 instance, holding out_ready low for holdCycles once valid.
   task automatic runTransaction(input logic [CH*SZ-1:0] vec, input logic [SZ-1:0] slope,
                                 input int holdCycles, input string name);
      int waitCnt;
      int edges;
      logic [CH*W2-1:0] held;
      logic [CH*W2-1:0] expVec;
      waitCnt = 0;
      @(negedge clk);
      while (!inReady && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      total++;
      if (inReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_ready: in_ready=%b required 1", name, inReady);
         return;
      end
      inData  = vec;
      inValid = 1'b1;
`ifdef LRELU_ALPHA_PORT_EN
      alphaIn = slope;
`endif
      @(posedge clk);
      sbQueue.push_back(refVector(vec, slope));
      #1;
      inValid = 1'b0;
      inData  = ~vec;
`ifdef LRELU_ALPHA_PORT_EN
      alphaIn = slope ^ 16'h00F0;
`endif
      edges = 0;
      while (!outValid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (!outValid) begin
            total++;
            if (busy !== 1'b1 || inReady !== 1'b0) begin
               bad++;
               $display("[TB] FAIL %s_busy: busy=%b in_ready=%b required 1/0", name, busy, inReady);
            end
         end
      end
      total++;
      if (outValid !== 1'b1 || edges != 5) begin
         bad++;
         $display("[TB] FAIL %s_latency: edges=%0d out_valid=%b required 5/1", name, edges, outValid);
      end
      held = outData;
      for (int c = 0; c < holdCycles; c++) begin
         @(negedge clk);
         inValid = c[0];
         inData  = {CH{16'h1234}} ^ vec;
         @(posedge clk);
         #1;
         total++;
         if (outValid !== 1'b1 || outData !== held || inReady !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_hold%0d: valid=%b stable=%b in_ready=%b done=%b required 1/1/0/0",
                     name, c, outValid, (outData === held), inReady, done);
         end
      end
      @(negedge clk);
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      total++;
      if (done !== 1'b1 || outValid !== 1'b0 || inReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_handshake: done=%b out_valid=%b in_ready=%b required 1/0/1",
                  name, done, outValid, inReady);
      end
      total++;
      if (sbQueue.size() == 0) begin
         bad++;
         $display("[TB] FAIL %s_scoreboard: queue size=0 required 1", name);
      end else begin
         expVec = sbQueue.pop_front();
         for (int e = 0; e < CH; e++) begin
            total++;
            if (held[e*W2 +: W2] !== expVec[e*W2 +: W2]) begin
               bad++;
               $display("[TB] FAIL %s_elem%0d: got=%h required=%h", name, e,
                        held[e*W2 +: W2], expVec[e*W2 +: W2]);
            end
         end
      end
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s_donePulse: done=%b required 0", name, done);
      end
   endtask

   task automatic test_reset();
      logic [CH*SZ-1:0] v;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (outValid !== 1'b0 || outData !== '0 || done !== 1'b0 || busy !== 1'b0 || inReady !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_state: valid=%b data0=%b done=%b busy=%b in_ready=%b required 0/1/0/0/0",
                  outValid, (outData === '0), done, busy, inReady);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (inReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_release: in_ready=%b required 1", inReady);
      end
      // Abort a transaction after two chunks have landed in out_data.
      v = fillVector(16'h0300);
      inData  = v;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (outValid !== 1'b0 || outData !== '0 || done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_abort: valid=%b data0=%b done=%b busy=%b required 0/1/0/0",
                  outValid, (outData === '0), done, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (inReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_abortReady: in_ready=%b required 1", inReady);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         total++;
         if (outValid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_noResult%0d: valid=%b done=%b required 0/0", c, outValid, done);
         end
      end
   endtask

   task automatic test_positive();
      runTransaction(fillVector(16'h0100), 16'd26, 0, "ones");
   endtask

   task automatic test_negative();
      runTransaction(fillVector(16'hFF00), 16'd26, 2, "minusOnes");
      runTransaction(fillVector(16'h0000), 16'd26, 0, "zeros");
   endtask

   task automatic test_extremes();
      logic [CH*SZ-1:0] v;
      logic [SZ-1:0] pat [8];
      pat = '{16'h7FFF, 16'h8000, 16'hFF00, 16'h0100, 16'h0001, 16'hFFFF, 16'h0000, 16'hC123};
      for (int i = 0; i < CH; i++) v[i*SZ +: SZ] = pat[i % 8];
      runTransaction(v, 16'd26, 1, "extremes");
      for (int i = 0; i < CH; i++) v[i*SZ +: SZ] = SZ'($urandom);
      runTransaction(v, 16'd26, 0, "random");
   endtask

   task automatic test_backpressure();
      logic [CH*SZ-1:0] v;
      for (int i = 0; i < CH; i++) v[i*SZ +: SZ] = SZ'($urandom);
      runTransaction(v, 16'd26, 10, "backpressure");
      runTransaction(fillVector(16'h8000), 16'd26, 0, "backToBack");
   endtask

   task automatic test_lanes3();
      logic [CH*SZ-1:0] v;
      logic [CH*W2-1:0] expVec;
      int edges;
      for (int i = 0; i < CH; i++) v[i*SZ +: SZ] = (i % 2 == 0) ? SZ'($urandom) : 16'h8000 + SZ'(i);
      @(negedge clk);
      inData3  = v;
      inValid3 = 1'b1;
`ifdef LRELU_ALPHA_PORT_EN
      alphaIn3 = 16'd26;
`endif
      @(posedge clk);
      sbQueue.push_back(refVector(v, 16'd26));
      #1;
      inValid3 = 1'b0;
      inData3  = '0;
      edges = 0;
      while (!outValid3 && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      total++;
      if (outValid3 !== 1'b1 || edges != 7) begin
         bad++;
         $display("[TB] FAIL lanes3_latency: edges=%0d out_valid=%b required 7/1", edges, outValid3);
      end
      expVec = sbQueue.pop_front();
      for (int e = 0; e < CH; e++) begin
         total++;
         if (outData3[e*W2 +: W2] !== expVec[e*W2 +: W2]) begin
            bad++;
            $display("[TB] FAIL lanes3_elem%0d: got=%h required=%h", e, outData3[e*W2 +: W2], expVec[e*W2 +: W2]);
         end
      end
      @(negedge clk);
      outReady3 = 1'b1;
      @(posedge clk);
      #1;
      outReady3 = 1'b0;
      total++;
      if (done3 !== 1'b1 || inReady3 !== 1'b1) begin
         bad++;
         $display("[TB] FAIL lanes3_handshake: done=%b in_ready=%b required 1/1", done3, inReady3);
      end
   endtask

`ifdef LRELU_ALPHA_PORT_EN
   task automatic test_alpha_port();
      runTransaction(fillVector(16'hFF00), 16'h0080, 0, "alphaPort");
   endtask
`endif

   initial begin
      reset     = 1'b1;
      inValid   = 1'b0;
      outReady  = 1'b0;
      inData    = '0;
      inValid3  = 1'b0;
      outReady3 = 1'b0;
      inData3   = '0;
`ifdef LRELU_ALPHA_PORT_EN
      alphaIn   = 16'd26;
      alphaIn3  = 16'd26;
`endif
      test_reset();
      test_positive();
      test_negative();
      test_extremes();
      test_backpressure();
      test_lanes3();
`ifdef LRELU_ALPHA_PORT_EN
      test_alpha_port();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
